// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter
// Two-master Wishbone arbiter in front of the SDRAM controller's single
// Wishbone slave port. Master 0 is the CPU data path, master 1 is the
// video/DMA fetcher. Single-beat accesses are serialised. Every output is
// registered. If the slave never acknowledges, the transfer is forced to
// complete after a bounded wait.
//
// state | meaning
// IDLE  | waiting for a master strobe; the arbitration decision is made here
// BUSY  | s_stb_o asserted, waiting for s_ack_i or for the timeout
// ACK   | the winner's ack (and timeout_o, if forced) is high for this cycle
//
// Ports
//   clk0, reset          clock and synchronous active-high reset
//   m0_* / m1_*          master ports: adr, stb, we, wrb, dat in; dat, ack out
//   s_adr_o .. s_dat_o   registered request to the controller
//   s_dat_i, s_ack_i     response from the controller
//   grant_o              owner of the current or last transfer (0 = m0)
//   timeout_o            one-cycle pulse on forced completion
module sdram_wb_arbiter #(
  parameter int              FIXED_PRIO   = 0,
  parameter int unsigned     ACK_TIMEOUT  = 1023,
  parameter logic [31:0]     TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic        clk0,
  input  logic        reset,
  input  logic [23:0] m0_adr_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_wrb_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic [23:0] m1_adr_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_wrb_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic [23:0] s_adr_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_wrb_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic        grant_o,
  output logic        timeout_o
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  // The counter holds the number of BUSY cycles already spent without an ack.
  // The timeout fires on the edge that would take it to ACK_TIMEOUT.
  localparam logic [CW-1:0] TO_LAST = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          last;
  logic [CW-1:0] cnt;
  logic          grant_go;
  logic          winner;
  logic          done;
  logic          forced;

  always_comb begin
    state_nx = state;
    grant_go = 1'b0;
    winner   = 1'b0;
    done     = 1'b0;
    forced   = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_stb_i || m1_stb_i) begin
          grant_go = 1'b1;
          state_nx = BUSY;
          if (m0_stb_i && m1_stb_i)
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last;
          else
            winner = m1_stb_i;
        end
      end
      BUSY: begin
        // A real ack takes precedence over a timeout landing on the same edge.
        if (s_ack_i) begin
          done     = 1'b1;
          state_nx = ACK;
        end else if ((ACK_TIMEOUT > 0) && (cnt == TO_LAST)) begin
          done     = 1'b1;
          forced   = 1'b1;
          state_nx = ACK;
        end
      end
      ACK: begin
        // Strobes are not looked at here, so the master that has just been
        // acked cannot be re-granted on its stale strobe.
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      s_adr_o   <= '0;
      s_stb_o   <= 1'b0;
      s_we_o    <= 1'b0;
      s_wrb_o   <= '0;
      s_dat_o   <= '0;
      m0_dat_o  <= '0;
      m1_dat_o  <= '0;
      m0_ack_o  <= 1'b0;
      m1_ack_o  <= 1'b0;
      grant_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nx;
      m0_ack_o  <= 1'b0;
      m1_ack_o  <= 1'b0;
      timeout_o <= 1'b0;

      if (grant_go) begin
        s_adr_o <= winner ? m1_adr_i : m0_adr_i;
        s_we_o  <= winner ? m1_we_i  : m0_we_i;
        s_wrb_o <= winner ? m1_wrb_i : m0_wrb_i;
        s_dat_o <= winner ? m1_dat_i : m0_dat_i;
        s_stb_o <= 1'b1;
        grant_o <= winner;
        cnt     <= '0;
      end

      if ((state == BUSY) && !done)
        cnt <= cnt + 1'b1;

      if (done) begin
        s_stb_o   <= 1'b0;
        last      <= grant_o;
        timeout_o <= forced;
        if (grant_o) begin
          m1_ack_o <= 1'b1;
          m1_dat_o <= forced ? TIMEOUT_DATA : s_dat_i;
        end else begin
          m0_ack_o <= 1'b1;
          m0_dat_o <= forced ? TIMEOUT_DATA : s_dat_i;
        end
      end
    end
  end

endmodule

// File: doc/sdram_wb_arbiter.md
Name: sdram_wb_arbiter

Overview:
- Two-master Wishbone arbiter in the clk0 domain in front of the DDR SDRAM controller's single Wishbone slave port.
- Master 0 is the CPU data path; master 1 is the video/DMA fetcher.
- Serialises single-beat accesses, registers all slave-side signals, and forces a bounded-latency completion if the SDRAM side never acknowledges.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between masters; 1 = master 0 always wins contention.
- ACK_TIMEOUT, 1023: maximum cycles s_stb_o may wait for s_ack_i before forced completion; 0 disables the timeout.
- TIMEOUT_DATA, 32'hDEADBEEF: read data returned on forced completion.

Ports:
- clk0  in  1  system clock (same as controller clk0)
- reset  in  1  synchronous, active-high reset
- m0_adr_i  in  24  master 0 word address [25:2]
- m0_stb_i  in  1  master 0 strobe
- m0_we_i  in  1  master 0 write enable
- m0_wrb_i  in  4  master 0 byte write enables
- m0_dat_i  in  32  master 0 write data
- m0_dat_o  out  32  master 0 read data
- m0_ack_o  out  1  master 0 acknowledge
- m1_adr_i, m1_stb_i, m1_we_i, m1_wrb_i, m1_dat_i, m1_dat_o, m1_ack_o: same widths and meanings for master 1
- s_adr_o  out  24  to controller wadr_i
- s_stb_o  out  1  to controller wstb_i
- s_we_o  out  1  to controller wwe_i
- s_wrb_o  out  4  to controller wwrb_i
- s_dat_o  out  32  to controller wdat_i
- s_dat_i  in  32  from controller wdat_o
- s_ack_i  in  1  from controller wack_o
- grant_o  out  1  owner of the current/last transfer (0 = m0, 1 = m1)
- timeout_o  out  1  one-cycle pulse on forced completion

Behaviour:
- Reset: all outputs 0, state IDLE, last-served pointer = 1 (m0 wins first contention), timeout counter 0. A reset mid-transfer aborts immediately: s_stb_o drops on that edge and no ack is issued.
- All outputs are registered.
- State machine has three states: IDLE, BUSY, ACK.
- IDLE, no strobe asserted: stay in IDLE.
- IDLE, exactly one strobe: grant that master.
- IDLE, both strobes:
  - FIXED_PRIO=1: grant m0.
  - FIXED_PRIO=0: grant the master that was not last served.
- On grant (one edge):
  - Latch the winner's adr/we/wrb/dat into s_*_o.
  - Set s_stb_o=1 and grant_o=winner; clear the timeout counter; go to BUSY.
- BUSY:
  - s_stb_o and all s_*_o are held constant.
  - Counter increments each cycle s_ack_i=0.
  - On the edge where s_ack_i=1:
    - s_stb_o<=0.
    - Winner's mX_dat_o<=s_dat_i; winner's mX_ack_o<=1.
    - Update the last-served pointer; go to ACK.
  - ACK_TIMEOUT>0 and counter reaches ACK_TIMEOUT with s_ack_i still 0:
    - Same actions as a real ack, except mX_dat_o<=TIMEOUT_DATA and timeout_o<=1.
  - s_ack_i arriving on the same edge as the timeout: the real ack wins, no timeout_o.
- ACK: mX_ack_o (and timeout_o, if set) is high for exactly this cycle, then go to IDLE. Strobes are ignored in ACK, so the completing master's still-high stb is not re-granted.
- Latency:
  - Grant edge to s_stb_o high: 1 cycle.
  - s_ack_i sampled to mX_ack_o high: 1 cycle.
  - Minimum master stb to ack: 3 cycles for a 1-cycle slave.
- Stray s_ack_i in IDLE or ACK is ignored.
- A non-granted master's stb stays pending, with no ack, until it is served.
- mX_dat_o holds its value between acks.
- Master inputs may change while the master is not granted; only values present on the grant edge are used.

Test Plan:
- Single m0 read: m0 stb, adr=24'h000010; slave acks 1 cycle after s_stb_o with dat 32'h12345678 -> s_adr_o=000010, s_we_o=0; m0_ack_o for 1 cycle; m0_dat_o=12345678; m1_ack_o stays 0.
- Contention, round-robin (FIXED_PRIO=0): both stb held continuously through 4 transfers -> grant order m0,m1,m0,m1; each master receives exactly 2 acks.
- Contention, fixed priority (FIXED_PRIO=1): both stb, m0 re-requesting right after each ack -> m1 served only when m0 stb=0 in IDLE.
- Write pass-through: m1 write, adr=24'hABCDE, wrb=4'b0101, dat=32'hCAFEF00D -> s_* carry exactly these values, constant until s_ack_i; m1_ack_o 1 cycle after.
- Timeout (ACK_TIMEOUT=8): no s_ack_i -> after 8 BUSY cycles s_stb_o=0, timeout_o and m0_ack_o high together for 1 cycle, m0_dat_o=DEADBEEF. Variant with s_ack_i on the 8th cycle -> no timeout_o, real data returned.
- Reset mid-BUSY: assert reset for 1 cycle while s_stb_o=1 -> next cycle all outputs 0, no ack; a pending m1 request is granted after reset deasserts.
